// File: rtl/spm_seq.sv
// Handshaked serial/parallel multiplier: x is streamed LSB-first through a carry-save adder array and the product is deserialised.
// Optional build macro SPM_SEQ_SIGNED_EN adds the signed_mode port for two's-complement operands.
module spm_seq #(
  parameter int unsigned BITS     = 32,
  parameter int unsigned XBITS    = 32,
  parameter int unsigned RST_SYNC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       a,
  input  logic [XBITS-1:0]      x,
`ifdef SPM_SEQ_SIGNED_EN
  input  logic                  signed_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS+XBITS-1:0] y,
  output logic                  busy
);

  localparam int unsigned N   = BITS + XBITS;
  localparam int unsigned LAT = XBITS + 2 * BITS;
  localparam int unsigned CW  = $clog2(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 in_ready_d, out_valid_d, busy_d;
  logic [N-1:0]         y_d;
  logic                 accept, capture;

  logic [RST_SYNC-1:0]  sync_q, sync_d;
  logic                 arr_rst_n, rel_d;

  logic [BITS-1:0]      a_q, s_q, c_q, s_d, c_d, s_up;
  logic [XBITS-1:0]     x_sh;
  logic [N-1:0]         prod;
  logic                 xbit, cap_bit;
  logic [BITS-1:0]      a_in;
  logic [XBITS-1:0]     x_in;

  // Reset-release synchronizer; its MSB is the array reset
  if (RST_SYNC > 1) begin : g_sync
    assign sync_d = {sync_q[RST_SYNC-2:0], 1'b1};
  end else begin : g_sync1
    assign sync_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign arr_rst_n = sync_q[RST_SYNC-1];
  assign rel_d     = sync_d[RST_SYNC-1];

`ifdef SPM_SEQ_SIGNED_EN
  logic neg_q, seen_q, neg_in;
  assign neg_in  = signed_mode & (a[BITS-1] ^ x[XBITS-1]);
  assign a_in    = (signed_mode && a[BITS-1])  ? BITS'(~a + BITS'(1))   : a;
  assign x_in    = (signed_mode && x[XBITS-1]) ? XBITS'(~x + XBITS'(1)) : x;
  // Serial two's-complement negate: copy up to the first 1, invert after it
  assign cap_bit = (neg_q && seen_q) ? ~s_d[0] : s_d[0];
`else
  assign a_in    = a;
  assign x_in    = x;
  assign cap_bit = s_d[0];
`endif

  // One carry-save column per multiplier bit; sums shift toward stage 0
  assign xbit = x_sh[0];
  assign s_up = s_q >> 1;

  always_comb begin
    s_d = '0;
    c_d = '0;
    for (int i = 0; i < int'(BITS); i++) begin
      s_d[i] = (a_q[i] & xbit) ^ s_up[i] ^ c_q[i];
      c_d[i] = ((a_q[i] & xbit) & s_up[i]) | ((a_q[i] & xbit) & c_q[i]) | (s_up[i] & c_q[i]);
    end
  end

  always_ff @(posedge clk or negedge arr_rst_n) begin
    if (!arr_rst_n) begin
      a_q  <= '0;
      x_sh <= '0;
      s_q  <= '0;
      c_q  <= '0;
      prod <= '0;
`ifdef SPM_SEQ_SIGNED_EN
      neg_q  <= 1'b0;
      seen_q <= 1'b0;
`endif
    end else if (accept) begin
      a_q  <= a_in;
      x_sh <= x_in;
      s_q  <= '0;
      c_q  <= '0;
      prod <= '0;
`ifdef SPM_SEQ_SIGNED_EN
      neg_q  <= neg_in;
      seen_q <= 1'b0;
`endif
    end else if (state == RUN) begin
      s_q  <= s_d;
      c_q  <= c_d;
      x_sh <= x_sh >> 1;
      if (capture) begin
        prod <= {cap_bit, prod[N-1:1]};
`ifdef SPM_SEQ_SIGNED_EN
        seen_q <= seen_q | s_d[0];
`endif
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      y         <= y_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid;
    y_d         = y;
    busy_d      = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_d = rel_d;
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        capture = (cnt < CW'(N));
        cnt_d   = cnt + CW'(1);
        if (cnt == CW'(LAT - 1)) state_d = DONE;
      end
      DONE: begin
        busy_d = 1'b1;
        if (!out_valid) begin
          out_valid_d = 1'b1;
          y_d         = prod;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_seq.sv
// Directed bench for spm_seq at BITS=4, XBITS=4: reset release, latency, hold, back-to-back, abort and products.
module tb_spm_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] x;
  logic       signed_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       busy;

  int checks = 0;
  int passed = 0;
  int lat;

  always #5 clk = ~clk;

  spm_seq #(.BITS(4), .XBITS(4), .RST_SYNC(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .x(x),
`ifdef SPM_SEQ_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 100);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tx, input logic sm,
                        input logic [31:0] exp, input int hold);
    int l;
    wait_ready();
    a = ta; x = tx; signed_mode = sm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~ta; x = ~tx; signed_mode = ~sm;
    chk("busy_run", 32'(busy), 32'd1);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    wait_out(l);
    chk("latency", 32'(l), 32'd13);
    chk("product", 32'(y), exp);
    repeat (hold) tick();
    chk("y_hold", 32'(y), exp);
    chk("valid_hold", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("no_turnaround", 32'(in_ready), 32'd0);
    tick();
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; x = '0; signed_mode = 1'b0;

    // Reset and synchronizer release
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel1_in_ready", 32'(in_ready), 32'd0);
    chk("rel1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rel2_in_ready", 32'(in_ready), 32'd1);
    chk("rel2_y", 32'(y), 32'd0);

    // Max operands with a stalled sink
    run_op(4'hF, 4'hF, 1'b0, 32'hE1, 5);

    // Abort mid-run while y still holds the previous product
    wait_ready();
    a = 4'd7; x = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    run_op(4'd2, 4'd3, 1'b0, 32'h06, 0);

    // Back-to-back with in_valid held high
    wait_ready();
    a = 4'd3; x = 4'd5; in_valid = 1'b1;
    tick();
    a = 4'd0; x = 4'd9;
    wait_out(lat);
    chk("b2b_lat1", 32'(lat), 32'd13);
    chk("b2b_y1", 32'(y), 32'h0F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_drop", 32'(out_valid), 32'd0);
    chk("b2b_no_turn", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b2b_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_lat2", 32'(lat), 32'd13);
    chk("b2b_y2", 32'(y), 32'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_drop2", 32'(out_valid), 32'd0);
    chk("y_kept", 32'(y), 32'h00);

    // Random unsigned products against the bench's own arithmetic
    for (int i = 0; i < 12; i++) begin
      int ra, rx;
      ra = int'($urandom_range(0, 15));
      rx = int'($urandom_range(0, 15));
      run_op(4'(ra), 4'(rx), 1'b0, 32'(ra * rx), i % 3);
    end

`ifdef SPM_SEQ_SIGNED_EN
    run_op(4'h8, 4'h8, 1'b1, 32'h40, 0);
    run_op(4'h8, 4'h7, 1'b1, 32'hC8, 1);
    run_op(4'hF, 4'h0, 1'b1, 32'h00, 0);
    run_op(4'h8, 4'h8, 1'b0, 32'h40, 0);
    run_op(4'h3, 4'hD, 1'b1, 32'hF7, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
